// File: rtl/rule_compactor.sv
// -----------------------------------------------------------------------------
// rule_compactor
//
// Removes zero (no-rule) lanes from the port-group filter output and repacks
// the surviving rule IDs, in arrival order, into dense beats while keeping the
// packet framing intact. Every input packet yields exactly one eop beat.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_usr_*        : input stream (data/valid/sop/eop/empty, ready out)
//                     lane i = in_usr_data[16i+15:16i], lane 0 oldest
//   out_usr_*       : compacted output stream (ready in)
//   in_rule_cnt     : running count of nonzero rule IDs accepted
//   out_pkt_cnt     : running count of eop beats transferred downstream
// -----------------------------------------------------------------------------
module rule_compactor #(
    parameter int  NUM_LANES  = 8,
    parameter int  LANE_WIDTH = 16,
    localparam int DATA_W     = NUM_LANES * LANE_WIDTH,
    localparam int EMPTY_W    = $clog2(DATA_W / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_usr_data,
    input  logic               in_usr_valid,
    input  logic               in_usr_sop,
    input  logic               in_usr_eop,
    input  logic [EMPTY_W-1:0] in_usr_empty,
    output logic               in_usr_ready,
    output logic [DATA_W-1:0]  out_usr_data,
    output logic               out_usr_valid,
    output logic               out_usr_sop,
    output logic               out_usr_eop,
    output logic [EMPTY_W-1:0] out_usr_empty,
    input  logic               out_usr_ready,
    output logic [31:0]        in_rule_cnt,
    output logic [31:0]        out_pkt_cnt
);

    // Accumulator holds up to 7 leftovers plus one full input beat.
    localparam int SLOTS = 2 * NUM_LANES - 1;
    localparam int CNT_W = $clog2(2 * NUM_LANES);

    typedef logic [SLOTS-1:0][LANE_WIDTH-1:0] slots_t;

    // First n slots of src placed into lanes 0..n-1; the rest are forced to 0
    // so stale accumulator contents never leak downstream.
    function automatic logic [DATA_W-1:0] take_lanes(input slots_t src,
                                                      input logic [CNT_W:0] n);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (k < int'(n)) begin
                res[k*LANE_WIDTH +: LANE_WIDTH] = src[k];
            end
        end
        return res;
    endfunction

    // Unused bytes in a beat carrying n (1..NUM_LANES) rule IDs.
    function automatic logic [EMPTY_W-1:0] calc_empty(input logic [CNT_W:0] n);
        int bytes;
        bytes = (NUM_LANES - int'(n)) * (LANE_WIDTH / 8);
        return EMPTY_W'(bytes);
    endfunction

    slots_t              r_acc;
    logic [CNT_W-1:0]    r_acc_n;
    logic                r_pend;
    logic                r_sop_need;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_out_sop;
    logic                r_out_eop;
    logic [EMPTY_W-1:0]  r_out_empty;
    logic [31:0]         r_in_rule_cnt;
    logic [31:0]         r_out_pkt_cnt;

    slots_t              w_ext;
    slots_t              w_shift;
    logic [CNT_W-1:0]    w_nz;
    logic [CNT_W:0]      w_t;
    logic [CNT_W:0]      w_t_rem;
    logic                w_out_free;
    logic                w_out_xfer;
    logic                w_accept;
    logic                w_t_ge_full;
    logic                w_t_gt_full;

    // Append nonzero lanes after the current accumulator contents, keeping
    // lane order stable.
    always_comb begin
        w_ext = r_acc;
        w_nz  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (in_usr_data[i*LANE_WIDTH +: LANE_WIDTH] != '0) begin
                if (int'(r_acc_n) + int'(w_nz) < SLOTS) begin
                    w_ext[int'(r_acc_n) + int'(w_nz)] = in_usr_data[i*LANE_WIDTH +: LANE_WIDTH];
                end
                w_nz = w_nz + CNT_W'(1);
            end
        end
    end

    // Entries past the first full beat slide down to slot 0.
    always_comb begin
        w_shift = '0;
        for (int k = 0; k < SLOTS - NUM_LANES; k++) begin
            w_shift[k] = w_ext[k + NUM_LANES];
        end
    end

    assign w_t         = {1'b0, r_acc_n} + {1'b0, w_nz};
    assign w_t_rem     = w_t - (CNT_W+1)'(NUM_LANES);
    assign w_t_ge_full = (w_t >= (CNT_W+1)'(NUM_LANES));
    assign w_t_gt_full = (w_t >  (CNT_W+1)'(NUM_LANES));

    assign w_out_free  = !r_out_valid || out_usr_ready;
    assign w_out_xfer  = r_out_valid && out_usr_ready;
    // Gated by rst so every output reads 0 while reset is held.
    assign in_usr_ready = !rst && !r_pend && w_out_free;
    assign w_accept    = in_usr_valid && in_usr_ready;

    // ---- stage boundary: accumulator update and output register load ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_n       <= '0;
            r_pend        <= 1'b0;
            r_sop_need    <= 1'b1;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_sop     <= 1'b0;
            r_out_eop     <= 1'b0;
            r_out_empty   <= '0;
            r_in_rule_cnt <= '0;
            r_out_pkt_cnt <= '0;
        end else begin
            if (w_out_xfer) begin
                r_out_valid <= 1'b0;
                if (r_out_eop) begin
                    r_out_pkt_cnt <= r_out_pkt_cnt + 32'd1;
                end
            end

            if (r_pend && w_out_free) begin
                // Tail of an oversized eop beat; input is stalled meanwhile.
                r_out_data  <= take_lanes(r_acc, {1'b0, r_acc_n});
                r_out_valid <= 1'b1;
                r_out_sop   <= r_sop_need;
                r_out_eop   <= 1'b1;
                r_out_empty <= calc_empty({1'b0, r_acc_n});
                r_acc_n     <= '0;
                r_pend      <= 1'b0;
                r_sop_need  <= 1'b1;
            end else if (w_accept) begin
                r_in_rule_cnt <= r_in_rule_cnt + 32'(w_nz);
                if (in_usr_eop) begin
                    if (w_t == '0) begin
                        // Packet with no rules still needs its eop marker.
                        r_out_data  <= '0;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= r_sop_need;
                        r_out_eop   <= 1'b1;
                        r_out_empty <= '0;
                        r_acc_n     <= '0;
                        r_sop_need  <= 1'b1;
                    end else if (!w_t_gt_full) begin
                        r_out_data  <= take_lanes(w_ext, w_t);
                        r_out_valid <= 1'b1;
                        r_out_sop   <= r_sop_need;
                        r_out_eop   <= 1'b1;
                        r_out_empty <= calc_empty(w_t);
                        r_acc_n     <= '0;
                        r_sop_need  <= 1'b1;
                    end else begin
                        r_out_data  <= take_lanes(w_ext, (CNT_W+1)'(NUM_LANES));
                        r_out_valid <= 1'b1;
                        r_out_sop   <= r_sop_need;
                        r_out_eop   <= 1'b0;
                        r_out_empty <= '0;
                        r_acc_n     <= w_t_rem[CNT_W-1:0];
                        r_pend      <= 1'b1;
                        r_sop_need  <= 1'b0;
                    end
                end else if (w_t_ge_full) begin
                    r_out_data  <= take_lanes(w_ext, (CNT_W+1)'(NUM_LANES));
                    r_out_valid <= 1'b1;
                    r_out_sop   <= r_sop_need;
                    r_out_eop   <= 1'b0;
                    r_out_empty <= '0;
                    r_acc_n     <= w_t_rem[CNT_W-1:0];
                    r_sop_need  <= 1'b0;
                end else begin
                    r_acc_n <= w_t[CNT_W-1:0];
                end
            end
        end
    end

    // Accumulator contents are data only; validity is carried by r_acc_n.
    always_ff @(posedge clk) begin
        if (!r_pend && w_accept) begin
            if (w_t_ge_full) begin
                r_acc <= w_shift;
            end else begin
                r_acc <= w_ext;
            end
        end
    end

    assign out_usr_data  = r_out_data;
    assign out_usr_valid = r_out_valid;
    assign out_usr_sop   = r_out_sop;
    assign out_usr_eop   = r_out_eop;
    assign out_usr_empty = r_out_empty;
    assign in_rule_cnt   = r_in_rule_cnt;
    assign out_pkt_cnt   = r_out_pkt_cnt;

    // sop is informational and empty is derived from zero lanes instead.
    logic w_unused;
    assign w_unused = in_usr_sop ^ (^in_usr_empty);

endmodule
